// File: rtl/operand_stack_if.sv
// Operand stack bus: command inputs and the stack status and data outputs.
// The master issues push/pop/flush/clear_err; the stack (slave) reports TOS, NOS, count and flags.
interface operand_stack_if #(
  parameter int WIDTH = 16,
  parameter int PTR_W = 5
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] push_data;
  logic             flush;
  logic             clear_err;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [PTR_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow_err;
  logic             underflow_err;

  modport master (
    output push, pop, push_data, flush, clear_err,
    input  tos, nos, count, empty, full, overflow_err, underflow_err
  );

  modport slave (
    input  push, pop, push_data, flush, clear_err,
    output tos, nos, count, empty, full, overflow_err, underflow_err
  );
endinterface

// File: rtl/operand_stack.sv
// LIFO operand stack with combinational TOS/NOS views and sticky overflow/underflow flags.
// mem[0] is the bottom entry; count doubles as the stack pointer.
module operand_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int PTR_W = 5
) (
  input  logic             clk,
  input  logic             async_reset,
  operand_stack_if.slave   bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [PTR_W-1:0] tos_ptr;
  logic [PTR_W-1:0] nos_ptr;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == PTR_W'(DEPTH));
  assign tos_ptr  = count_q - PTR_W'(1);
  assign nos_ptr  = count_q - PTR_W'(2);

  always_comb begin
    count_d     = count_q;
    // A new error in this cycle overrides a simultaneous clear.
    overflow_d  = overflow_q  & ~bus.clear_err;
    underflow_d = underflow_q & ~bus.clear_err;
    mem_we      = 1'b0;
    mem_waddr   = count_q[AW-1:0];

    if (bus.flush) begin
      count_d = '0;
    end else if (bus.push && !bus.pop) begin
      if (is_full) begin
        overflow_d = 1'b1;
      end else begin
        mem_we  = 1'b1;
        count_d = count_q + PTR_W'(1);
      end
    end else if (bus.pop && !bus.push) begin
      if (is_empty) begin
        underflow_d = 1'b1;
      end else begin
        count_d = count_q - PTR_W'(1);
      end
    end else if (bus.push && bus.pop) begin
      mem_we = 1'b1;
      if (is_empty) begin
        // Replace on an empty stack degrades to a push but still flags the missing operand.
        mem_waddr   = '0;
        count_d     = PTR_W'(1);
        underflow_d = 1'b1;
      end else begin
        mem_waddr = tos_ptr[AW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; the write is suppressed while reset is held so no stale word survives.
  always_ff @(posedge clk) begin
    if (async_reset && mem_we) begin
      mem_q[mem_waddr] <= bus.push_data;
    end
  end

  assign bus.tos           = is_empty ? '0 : mem_q[tos_ptr[AW-1:0]];
  assign bus.nos           = (count_q >= PTR_W'(2)) ? mem_q[nos_ptr[AW-1:0]] : '0;
  assign bus.count         = count_q;
  assign bus.empty         = is_empty;
  assign bus.full          = is_full;
  assign bus.overflow_err  = overflow_q;
  assign bus.underflow_err = underflow_q;

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack: each stimulus step queues its expected state,
// and an event-driven monitor pops and compares against the DUT outputs.
module tb_operand_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int PTR_W = 5;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    int               count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;
  } exp_t;

  logic clk;
  logic async_reset;
  exp_t exp_q[$];
  event chk_ev;
  int   checks;
  int   errors;

  operand_stack_if #(.WIDTH(WIDTH), .PTR_W(PTR_W)) bus ();

  operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_dut (
    .clk         (clk),
    .async_reset (async_reset),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input string field, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, req);
    end
  endtask

  // Monitor: compares every queued expectation when the stimulus signals a sample point.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(e.name, "tos",   int'(bus.tos),           int'(e.tos));
        chk(e.name, "nos",   int'(bus.nos),           int'(e.nos));
        chk(e.name, "count", int'(bus.count),         e.count);
        chk(e.name, "empty", int'(bus.empty),         int'(e.empty));
        chk(e.name, "full",  int'(bus.full),          int'(e.full));
        chk(e.name, "ovf",   int'(bus.overflow_err),  int'(e.ovf));
        chk(e.name, "unf",   int'(bus.underflow_err), int'(e.unf));
        $display("txn %-14s tos=%0d nos=%0d count=%0d empty=%0b full=%0b ovf=%0b unf=%0b",
                 e.name, bus.tos, bus.nos, bus.count, bus.empty, bus.full,
                 bus.overflow_err, bus.underflow_err);
      end
    end
  end

  task automatic expect_now(input string name, input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] n,
                            input int c, input logic e, input logic f, input logic o, input logic u);
    exp_t x;
    x.name = name; x.tos = t; x.nos = n; x.count = c;
    x.empty = e; x.full = f; x.ovf = o; x.unf = u;
    exp_q.push_back(x);
    ->chk_ev;
  endtask

  task automatic step(input string name, input logic pu, input logic po, input logic [WIDTH-1:0] d,
                      input logic fl, input logic ce,
                      input logic [WIDTH-1:0] t, input logic [WIDTH-1:0] n, input int c,
                      input logic e, input logic f, input logic o, input logic u);
    @(negedge clk);
    bus.push = pu; bus.pop = po; bus.push_data = d; bus.flush = fl; bus.clear_err = ce;
    @(posedge clk);
    #1;
    expect_now(name, t, n, c, e, f, o, u);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    async_reset = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = '0; bus.flush = 1'b0; bus.clear_err = 1'b0;
    #3;
    expect_now("in_reset", 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    async_reset = 1'b1;

    //   name          pu po data fl ce   tos   nos  cnt e f o u
    step("idle",        0, 0, 0,    0, 0, 0,    0,    0, 1, 0, 0, 0);
    step("push5040",    1, 0, 5040, 0, 0, 5040, 0,    1, 0, 0, 0, 0);
    step("push7",       1, 0, 7,    0, 0, 7,    5040, 2, 0, 0, 0, 0);
    step("pop",         0, 1, 0,    0, 0, 5040, 0,    1, 0, 0, 0, 0);
    step("pop_last",    0, 1, 0,    0, 0, 0,    0,    0, 1, 0, 0, 0);

    for (int k = 1; k <= DEPTH; k++) begin
      step($sformatf("fill%0d", k), 1, 0, 16'(k), 0, 0, 16'(k), 16'(k - 1), k, 0, k == DEPTH, 0, 0);
    end
    step("push_full",   1, 0, 99,   0, 0, 16,   15,  16, 0, 1, 1, 0);
    step("replace_full",1, 1, 42,   0, 0, 42,   15,  16, 0, 1, 1, 0);
    step("clr_ovf",     0, 0, 0,    0, 1, 42,   15,  16, 0, 1, 0, 0);
    step("flush",       0, 0, 0,    1, 0, 0,    0,    0, 1, 0, 0, 0);

    step("pop_empty",   0, 1, 0,    0, 0, 0,    0,    0, 1, 0, 0, 1);
    step("clr_unf",     0, 0, 0,    0, 1, 0,    0,    0, 1, 0, 0, 0);
    step("clr_and_pop", 0, 1, 0,    0, 1, 0,    0,    0, 1, 0, 0, 1);
    step("clr_unf2",    0, 0, 0,    0, 1, 0,    0,    0, 1, 0, 0, 0);

    step("repl_empty",  1, 1, 5,    0, 0, 5,    0,    1, 0, 0, 0, 1);
    step("flush_push",  1, 0, 3,    1, 0, 0,    0,    0, 1, 0, 0, 1);
    step("clr_unf3",    0, 0, 0,    0, 1, 0,    0,    0, 1, 0, 0, 0);

    step("push1",       1, 0, 1,    0, 0, 1,    0,    1, 0, 0, 0, 0);
    step("push2",       1, 0, 2,    0, 0, 2,    1,    2, 0, 0, 0, 0);
    step("push3",       1, 0, 3,    0, 0, 3,    2,    3, 0, 0, 0, 0);

    // Reset lands between edges; a push held during reset must leave no trace.
    @(negedge clk);
    bus.push = 1'b1; bus.pop = 1'b0; bus.push_data = 77; bus.flush = 1'b0; bus.clear_err = 1'b0;
    @(posedge clk);
    #3;
    async_reset = 1'b0;
    #1;
    expect_now("async_rst", 0, 0, 0, 1, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    bus.push = 1'b0;
    async_reset = 1'b1;
    step("post_rst",    0, 0, 0,    0, 0, 0,    0,    0, 1, 0, 0, 0);
    step("push8",       1, 0, 8,    0, 0, 8,    0,    1, 0, 0, 0, 0);
    step("push9",       1, 0, 9,    0, 0, 9,    8,    2, 0, 0, 0, 0);

    @(negedge clk);
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.clear_err = 1'b0;
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
